ones_count_feeder: RTL and testbench
====================================

Name: ones_count_feeder

Overview:
- Upstream stage of the ones-count datapath. Buffers W-bit words from a valid/ready producer in a small FIFO.
- Dispatches one word at a time to the ones counter: drives d_in, pulses d_in_ready for one cycle, then waits for the counter's dor pulse before dispatching the next word.
- Guarantees the counter never receives a word while it is busy, and flags protocol violations.

Parameters:
- W, 30, data word width; must match the ones counter's width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- CW, 8, width of the dispatched-word counter.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_L  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  W  producer word.
- in_ready  output  1  FIFO can accept a word (not full).
- d_in  output  W  word presented to the counter; registered.
- d_in_ready  output  1  one-cycle dispatch strobe to the counter.
- dor  input  1  counter's result-ready pulse; marks the end of the current word.
- busy  output  1  a word is dispatched and its dor is still outstanding (ISSUE or WAIT).
- fifo_count  output  $clog2(DEPTH)+1  number of words held in the FIFO.
- issued_cnt  output  CW  count of words dispatched; wraps modulo 2^CW.
- proto_err  output  1  sticky: dor was seen while not in WAIT.

Behaviour:
- Reset, sampled on posedge clock with reset_L==0, overrides everything:
  - state=IDLE, FIFO emptied, fifo_count=0.
  - d_in=0, d_in_ready=0, busy=0, issued_cnt=0, proto_err=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation drops any dispatched word and all buffered words. The system must reset the counter in the same cycle.
- FIFO:
  - in_ready = (fifo_count != DEPTH), computed from the current count only; a same-cycle pop does not open a slot.
  - Push when in_valid && in_ready. Pop only on the ISSUE->WAIT edge.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - in_valid while full is not an error; the producer holds in_data until in_ready.
  - Read and write pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: if fifo_count!=0, go to ISSUE and load d_in <= FIFO head at that edge. Otherwise stay.
  - ISSUE: d_in_ready=1 for exactly this cycle. At the next edge, pop the head, increment issued_cnt, go to WAIT.
  - WAIT: d_in_ready=0, d_in held stable. On dor==1:
    - if fifo_count!=0 (after any push in that cycle's edge is excluded; count as seen this cycle), go directly to ISSUE and load d_in <= head;
    - else go to IDLE.
  - busy=1 in ISSUE and WAIT.
- Latency:
  - Word pushed into an empty FIFO at edge N while IDLE → ISSUE entered at edge N+1, d_in_ready high during cycle N+1→N+2.
  - dor high in cycle M with FIFO non-empty → d_in_ready high in cycle M+1, when the counter is back in its idle state.
- d_in only changes on entry to ISSUE.
- dor in IDLE or ISSUE is ignored for state purposes and sets proto_err=1. proto_err clears only on reset.
- dor held high for several cycles in WAIT is treated as a single event; the following ISSUE cycle flags proto_err if dor is still high.
- issued_cnt wraps from 2^CW-1 to 0 with no flag.

Decomposition:
- Package ones_count_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT} feeder_state_t;
  - shared default width constant ONES_W=30, used by both feeder and counter.
- Sub-module word_fifo #(W, DEPTH): synchronous FIFO with push, pop, head, count, full, empty; reset_L active-low synchronous.
- Top level contains the FSM, the d_in register, issued_cnt and proto_err.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles → in_ready=1, d_in=0, d_in_ready=0, busy=0, fifo_count=0, issued_cnt=0, proto_err=0.
- Single word: push 30'h0000_0007 at edge 0 → d_in=7 and d_in_ready=1 during cycle 1 only, busy=1. Assert dor 10 cycles later → busy=0 next cycle, issued_cnt=1.
- Fill/backpressure: keep dor low, push 5 words 1..5 back-to-back → word 1 dispatched, FIFO holds 2..5, fifo_count=4, in_ready=0. A 6th in_valid is stalled until a dor pulse, after which d_in=2 with d_in_ready the cycle after dor.
- Back-to-back drain: with 3 words queued, pulse dor each time the FSM reaches WAIT → d_in_ready pulses exactly once per word, d_in sequence matches push order, issued_cnt=3, FSM ends in IDLE.
- Protocol error: pulse dor while IDLE → proto_err=1 and stays 1 through later normal traffic, with no change to FIFO or state.
- Reset mid-WAIT: 2 words queued, reset_L=0 for 1 cycle → fifo_count=0, busy=0, d_in=0, no d_in_ready afterwards without new pushes.

Source files
------------

// File: rtl/ones_count_pkg.sv
// rtl/ones_count_pkg.sv - shared types and constants for the ones-count datapath
package ones_count_pkg;

    // Default word width shared by the feeder and the ones counter.
    localparam int ONES_W = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - synchronous word FIFO buffering producer words for the feeder
//
// Ports:
//   clock, reset_L : clock and synchronous active-low reset
//   push, wdata    : write request and word; ignored while full
//   pop            : read request; ignored while empty
//   head           : word at the read pointer (valid when !empty)
//   count          : number of words held, 0..DEPTH
//   full, empty    : occupancy flags derived from count
module word_fifo
    import ones_count_pkg::*;
#(
    parameter int W     = ONES_W,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ones_count_feeder.sv
// rtl/ones_count_feeder.sv - buffers producer words and dispatches them one at a time to the ones counter
//
// Ports:
//   clock, reset_L      : clock and synchronous active-low reset
//   in_valid, in_data   : producer word offer
//   in_ready            : FIFO has a free slot (from current count only)
//   d_in, d_in_ready    : registered word and one-cycle dispatch strobe to the counter
//   dor                 : counter's result-ready pulse, ends the current word
//   busy                : a dispatched word is still awaiting its dor
//   fifo_count          : words buffered
//   issued_cnt          : words dispatched, wraps modulo 2^CW
//   proto_err           : sticky, dor arrived while no word was outstanding
module ones_count_feeder
    import ones_count_pkg::*;
#(
    parameter int W     = ONES_W,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clock,
    input  logic                     reset_L,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_data,
    output logic                     in_ready,
    output logic [W-1:0]             d_in,
    output logic                     d_in_ready,
    input  logic                     dor,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CW-1:0]            issued_cnt,
    output logic                     proto_err
);

    feeder_state_t state;
    feeder_state_t state_nxt;
    logic [W-1:0]  head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          load;

    word_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_L (reset_L),
        .push    (in_valid),
        .wdata   (in_data),
        .pop     (pop),
        .head    (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready = !full;
    assign busy     = (state != IDLE);

    // The head is captured into d_in when ISSUE is entered but only popped
    // when ISSUE is left, so the FIFO slot is held until the strobe is out.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        load       = 1'b0;
        d_in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = ISSUE;
                    load      = 1'b1;
                end
            end
            ISSUE: begin
                d_in_ready = 1'b1;
                pop        = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (dor) begin
                    if (!empty) begin
                        state_nxt = ISSUE;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state      <= IDLE;
            d_in       <= '0;
            issued_cnt <= '0;
            proto_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                d_in <= head;
            end
            if (pop) begin
                issued_cnt <= issued_cnt + 1'b1;
            end
            // A dor that lingers into the next ISSUE is also caught here.
            if (dor && (state != WAIT)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ones_count_feeder.sv
// tb/tb_ones_count_feeder.sv - self-checking bench for ones_count_feeder
module tb_ones_count_feeder;

    localparam int W     = 30;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int NW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset_L = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          dor = 1'b0;
    logic          in_ready;
    logic [W-1:0]  d_in;
    logic          d_in_ready;
    logic          busy;
    logic [NW-1:0] fifo_count;
    logic [CW-1:0] issued_cnt;
    logic          proto_err;

    int total = 0;
    int bad   = 0;

    ones_count_feeder #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .d_in       (d_in),
        .d_in_ready (d_in_ready),
        .dor        (dor),
        .busy       (busy),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt),
        .proto_err  (proto_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: a queue of buffered words, the word currently
    // handed to the counter, and whether the counter still owes a dor.
    logic [W-1:0]  mq[$];
    logic [W-1:0]  m_din;
    logic [CW-1:0] m_cnt;
    bit            m_strobe;
    bit            m_busy;
    bit            m_err;
    bit            started = 1'b0;
    bit            m_push;
    bit            m_owed;

    always @(posedge clock) begin
        if (!reset_L) begin
            mq.delete();
            m_din    = '0;
            m_cnt    = '0;
            m_strobe = 1'b0;
            m_busy   = 1'b0;
            m_err    = 1'b0;
            started  = 1'b1;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_owed = m_busy && !m_strobe;
            if (dor && !m_owed) m_err = 1'b1;
            if (m_strobe) begin
                void'(mq.pop_front());
                m_cnt    = m_cnt + 1'b1;
                m_strobe = 1'b0;
            end else if (!m_busy && mq.size() != 0) begin
                m_din    = mq[0];
                m_strobe = 1'b1;
                m_busy   = 1'b1;
            end else if (m_owed && dor) begin
                if (mq.size() != 0) begin
                    m_din    = mq[0];
                    m_strobe = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end
            if (m_push) mq.push_back(in_data);
        end
    end

    logic [W-1:0] seen[$];
    int           strobes = 0;

    always @(negedge clock) begin
        if (started) begin
            chk("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("d_in",       32'(d_in),       32'(m_din));
            chk("d_in_ready", 32'(d_in_ready), 32'(m_strobe));
            chk("busy",       32'(busy),       32'(m_busy));
            chk("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
            chk("proto_err",  32'(proto_err),  32'(m_err));
            if (d_in_ready) begin
                seen.push_back(d_in);
                strobes++;
            end
        end
    end

    // All stimulus tasks start and finish at a negedge.
    task automatic do_reset(input int n);
        reset_L = 1'b0;
        repeat (n) @(negedge clock);
        reset_L = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] w);
        int guard = 0;
        bit took;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            took = in_ready;
            @(negedge clock);
            guard++;
        end while (!took && guard < 200);
        in_valid = 1'b0;
        chk("send_accept", 32'(took), 32'd1);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            while (!(busy && !d_in_ready) && guard < 50) begin
                @(negedge clock);
                guard++;
            end
            chk("drain_reach_wait", 32'(busy && !d_in_ready), 32'd1);
            dor = 1'b1;
            @(negedge clock);
            dor = 1'b0;
        end
    endtask

    initial begin
        int n0;

        // Reset state
        do_reset(2);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_d_in",       32'(d_in),       32'd0);
        chk("rst_d_in_ready", 32'(d_in_ready), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_issued",     32'(issued_cnt), 32'd0);
        chk("rst_proto_err",  32'(proto_err),  32'd0);

        // Single word: strobe one cycle after the push edge
        send(30'h0000_0007);
        chk("sw_idle_strobe", 32'(d_in_ready), 32'd0);
        @(negedge clock);
        chk("sw_d_in",        32'(d_in),       32'd7);
        chk("sw_strobe",      32'(d_in_ready), 32'd1);
        chk("sw_busy",        32'(busy),       32'd1);
        @(negedge clock);
        chk("sw_strobe_once", 32'(d_in_ready), 32'd0);
        chk("sw_busy_wait",   32'(busy),       32'd1);
        repeat (8) @(negedge clock);
        dor = 1'b1;
        @(negedge clock);
        dor = 1'b0;
        chk("sw_busy_done",   32'(busy),       32'd0);
        chk("sw_issued",      32'(issued_cnt), 32'd1);

        // Fill and backpressure
        for (int i = 1; i <= 5; i++) send(W'(i));
        chk("fill_count",    32'(fifo_count), 32'd4);
        chk("fill_in_ready", 32'(in_ready),   32'd0);
        chk("fill_d_in",     32'(d_in),       32'd1);
        fork
            send(30'd6);
            begin
                repeat (3) @(negedge clock);
                dor = 1'b1;
                @(negedge clock);
                dor = 1'b0;
                chk("fill_next_d_in",   32'(d_in),       32'd2);
                chk("fill_next_strobe", 32'(d_in_ready), 32'd1);
            end
        join
        drain(5);
        @(negedge clock);
        chk("fill_issued", 32'(issued_cnt), 32'd7);
        chk("fill_idle",   32'(busy),       32'd0);
        chk("fill_empty",  32'(fifo_count), 32'd0);

        // Back-to-back drain ordering
        do_reset(1);
        seen.delete();
        send(30'h3FFF_FFFF);
        send(30'h1555_5555);
        send(30'h2AAA_AAAA);
        drain(3);
        repeat (2) @(negedge clock);
        chk("b2b_issued",  32'(issued_cnt),  32'd3);
        chk("b2b_idle",    32'(busy),        32'd0);
        chk("b2b_strobes", 32'(seen.size()), 32'd3);
        chk("b2b_word0",   32'(seen[0]),     32'h3FFF_FFFF);
        chk("b2b_word1",   32'(seen[1]),     32'h1555_5555);
        chk("b2b_word2",   32'(seen[2]),     32'h2AAA_AAAA);

        // Protocol error: dor while idle
        dor = 1'b1;
        @(negedge clock);
        dor = 1'b0;
        chk("pe_set",   32'(proto_err),  32'd1);
        chk("pe_busy",  32'(busy),       32'd0);
        chk("pe_count", 32'(fifo_count), 32'd0);
        send(30'h5);
        drain(1);
        repeat (2) @(negedge clock);
        chk("pe_sticky", 32'(proto_err),  32'd1);
        chk("pe_issued", 32'(issued_cnt), 32'd4);

        // Reset while waiting with two words buffered
        send(30'd10);
        send(30'd11);
        send(30'd12);
        chk("rw_count_pre", 32'(fifo_count), 32'd2);
        chk("rw_busy_pre",  32'(busy),       32'd1);
        do_reset(1);
        chk("rw_count", 32'(fifo_count), 32'd0);
        chk("rw_busy",  32'(busy),       32'd0);
        chk("rw_d_in",  32'(d_in),       32'd0);
        chk("rw_err",   32'(proto_err),  32'd0);
        n0 = strobes;
        repeat (6) @(negedge clock);
        chk("rw_no_strobe", 32'(strobes), 32'(n0));

        // issued_cnt wraps after 2^CW dispatches
        for (int i = 0; i < 256; i++) begin
            send(W'(i));
            drain(1);
        end
        repeat (2) @(negedge clock);
        chk("wrap_issued", 32'(issued_cnt), 32'd0);
        chk("wrap_err",    32'(proto_err),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
